// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder.
package spi_pkg;

    localparam int SPI_WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous input bit.
// RST_VAL is the idle line level, so leaving reset does not fake an edge.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            dout <= RST_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// Mode-0, MSB-first SPI responder oversampled by clk, with a one-entry
// transmit holding register and a one-cycle receive strobe.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | deselected; miso held 0, waiting for cs_n fall
// ACTIVE | selected; sclk rises shift mosi in, sclk falls shift miso out
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             tx_underrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    spi_state_t state_q, state_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-2:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;

    logic do_load, do_tx_shift, do_rx, do_abort, rx_last;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .din(sclk), .dout(sclk_s));
    spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .din(cs_n), .dout(cs_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .din(mosi), .dout(mosi_s));

    // Delayed copies of synced sclk/cs_n for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-cycle actions; a cs_n edge masks any sclk edge.
    always_comb begin
        state_d     = state_q;
        do_load     = 1'b0;
        do_tx_shift = 1'b0;
        do_rx       = 1'b0;
        do_abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    do_load = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    do_abort = 1'b1;
                end else if (sclk_rise) begin
                    do_rx = 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt == '0) do_load = 1'b1;
                    else               do_tx_shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_last = do_rx && (bit_cnt == LAST_BIT);
    assign rx_next = {rx_shift, mosi_s};

    // Bit counter: cleared at selection/deselection, wraps after a full word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (do_abort || (state_q == IDLE && cs_fall)) begin
            bit_cnt <= '0;
        end else if (do_rx) begin
            bit_cnt <= rx_last ? '0 : bit_cnt + CW'(1);
        end
    end

    // Transmit shifter: load from holding register (zeros on underrun), shift, or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift    <= '0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (do_load) begin
                if (hold_full) begin
                    tx_shift <= hold_data;
                end else begin
                    tx_shift    <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (do_tx_shift) begin
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end else if (do_abort) begin
                tx_shift <= '0;
            end
        end
    end

    // Receive shifter and completed-word output with one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (do_rx) begin
                rx_shift <= rx_next[WIDTH-2:0];
                if (rx_last) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

    // Holding register: a load empties it, a write fills it only when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (do_load && hold_full) begin
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end
    end

    assign tx_ready = ~hold_full;
    assign busy     = (state_q == ACTIVE);
    assign miso     = (state_q == ACTIVE) ? tx_shift[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench: bit-banged SPI master plus a word-level reference model.
module tb_spi_slave_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk;
    logic         cs_n;
    logic         mosi;
    logic         miso;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    logic         tx_underrun;

    int n_tests = 0;
    int n_fail  = 0;

    int           rxv_cnt  = 0;
    int           urun_cnt = 0;
    logic [W-1:0] rx_q[$];

    // Per-transfer stimulus: master words, slave tx words, whether each tx word is supplied.
    logic [W-1:0] mw[4];
    logic [W-1:0] tw[4];
    bit           sup[4];

    always #5 clk = ~clk;

    spi_slave_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .tx_underrun(tx_underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                rxv_cnt++;
                rx_q.push_back(rx_data);
            end
            if (tx_underrun) urun_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        rxv_cnt  = 0;
        urun_cnt = 0;
        rx_q.delete();
    endtask

    task automatic write_tx(input logic [W-1:0] d);
        int t = 0;
        while (!tx_ready && t < 200) begin
            wait_clk(1);
            t++;
        end
        check("tx_ready_wait", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_clk(5);
    endtask

    task automatic xfer_bit(input logic b, output logic m);
        sclk = 1'b0;
        mosi = b;
        wait_clk(5);
        m    = miso;
        sclk = 1'b1;
        wait_clk(5);
    endtask

    // Deselect while sclk is still high, then return sclk to idle.
    task automatic cs_high();
        cs_n = 1'b1;
        wait_clk(5);
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(6);
    endtask

    // One transfer of nw words (abort_bits < W aborts the first word early).
    task automatic run_xfer(input int nw, input int abort_bits, input string tag);
        logic [W-1:0] got[4];
        logic         m;
        int           full_words;
        int           exp_urun;
        int           nbits;
        clear_mon();
        if (sup[0]) write_tx(tw[0]);
        cs_low();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_ready_after_cs"}, 32'(tx_ready), 32'd1);
        nbits = 0;
        for (int w = 0; w < nw; w++) begin
            got[w] = '0;
            for (int i = W - 1; i >= 0; i--) begin
                if (nbits < abort_bits || abort_bits >= W) begin
                    xfer_bit(mw[w][i], m);
                    got[w][i] = m;
                    nbits++;
                    if (i == W - 3 && w + 1 < nw && sup[w + 1]) write_tx(tw[w + 1]);
                end
            end
        end
        cs_high();
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_miso_idle"}, 32'(miso), 32'd0);
        full_words = (abort_bits < W) ? 0 : nw;
        exp_urun = 0;
        for (int w = 0; w < ((abort_bits < W) ? 1 : nw); w++)
            if (!sup[w]) exp_urun++;
        check({tag, "_rx_count"}, 32'(rxv_cnt), 32'(full_words));
        check({tag, "_underruns"}, 32'(urun_cnt), 32'(exp_urun));
        for (int w = 0; w < full_words; w++) begin
            if (w < rx_q.size())
                check($sformatf("%s_rx_w%0d", tag, w), 32'(rx_q[w]), 32'(mw[w]));
            check($sformatf("%s_miso_w%0d", tag, w), 32'(got[w]), sup[w] ? 32'(tw[w]) : 32'd0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic m;
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        wait_clk(4);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        clear_mon();
        wait_clk(10);
        check("rel_rx_valid_cnt", 32'(rxv_cnt), 32'd0);
        check("rel_underrun_cnt", 32'(urun_cnt), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);

        // Single word.
        mw[0] = 8'h3C; tw[0] = 8'hA5; sup[0] = 1;
        run_xfer(1, W, "single");

        // Back-to-back with mid-word write.
        mw[0] = 8'h12; mw[1] = 8'h34; tw[0] = 8'h56; tw[1] = 8'h78; sup[0] = 1; sup[1] = 1;
        run_xfer(2, W, "b2b");

        // Underrun.
        mw[0] = 8'h9B; sup[0] = 0;
        run_xfer(1, W, "urun");

        // Abort after 5 bits, then a clean word.
        mw[0] = 8'hFF; tw[0] = 8'h11; sup[0] = 1;
        run_xfer(1, 5, "abort");
        mw[0] = 8'hC3; tw[0] = 8'h5A; sup[0] = 1;
        run_xfer(1, W, "post_abort");

        // Asynchronous reset after 3 bits.
        write_tx(8'hE7);
        cs_low();
        for (int i = 0; i < 3; i++) xfer_bit(1'b1, m);
        #2 rst = 1'b1;
        #1;
        check("arst_miso", 32'(miso), 32'd0);
        check("arst_tx_ready", 32'(tx_ready), 32'd1);
        check("arst_rx_data", 32'(rx_data), 32'd0);
        check("arst_rx_valid", 32'(rx_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_underrun", 32'(tx_underrun), 32'd0);
        cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        clear_mon();
        wait_clk(10);
        check("arst_no_pulses", 32'(rxv_cnt + urun_cnt), 32'd0);
        mw[0] = 8'h4D; tw[0] = 8'hB2; sup[0] = 1;
        run_xfer(1, W, "post_rst");

        // Randomized transfers.
        for (int k = 0; k < 14; k++) begin
            int nw;
            int ab;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < 4; w++) begin
                mw[w]  = W'($urandom);
                tw[w]  = W'($urandom);
                sup[w] = ($urandom_range(0, 3) != 0);
            end
            ab = W;
            if (nw == 1 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, W - 1);
            run_xfer(nw, ab, $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
